// File: rtl/spi_fpga_master_slave.sv
`timescale 1ns/1ps
// spi_fpga_master_slave: single-clock SPI master engine plus SPI slave engine with separate pin sets.
// Latency: master holds CS low for (2*PACK_LENGTH+2)*HALF clocks and pulses done as CS rises;
//          slave pins pass a 2-FF synchronizer, so MISO updates 3 clocks after a pin edge.
// Backpressure: none. Launch edges outside idle are dropped; the slave follows its external master.
// Ports: IN_CLOCK/IN_RESET_N (clock, async active-low reset);
//   master: IN_LAUNCH, IN_MASTER_DATA, IN_MISO -> OUT_MOSI, OUT_CS, OUT_SCLK,
//           OUT_MASTER_RECEIVE_DATA, OUT_MASTER_ACTION_DONE;
//   slave:  IN_SLAVE_TRANSMIT_DATA, IN_SLAVE_MOSI, IN_SLAVE_CS, IN_SLAVE_SCLK ->
//           OUT_SLAVE_MISO, OUT_SLAVE_RECEIVE_DATA, OUT_SLAVE_DONE.
module spi_fpga_master_slave #(
  parameter int BIT_PER_SECOND                    = 6250000,
  parameter int CLOCK_FREQUENCY                   = 50000000,
  parameter int PACK_LENGTH                       = 8,
  parameter int CPOL                              = 0,
  parameter int CPHA                              = 0,
  parameter int MASTER_PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int MASTER_PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int SLAVE_PACK_BIT_SEQUENCE_TRANSMIT  = 1,
  parameter int SLAVE_PACK_BIT_SEQUENCE_RECEIVE   = 1
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET_N,
  input  logic                   IN_LAUNCH,
  input  logic [PACK_LENGTH-1:0] IN_MASTER_DATA,
  input  logic                   IN_MISO,
  output logic                   OUT_MOSI,
  output logic                   OUT_CS,
  output logic                   OUT_SCLK,
  output logic [PACK_LENGTH-1:0] OUT_MASTER_RECEIVE_DATA,
  output logic                   OUT_MASTER_ACTION_DONE,
  input  logic [PACK_LENGTH-1:0] IN_SLAVE_TRANSMIT_DATA,
  input  logic                   IN_SLAVE_MOSI,
  input  logic                   IN_SLAVE_CS,
  input  logic                   IN_SLAVE_SCLK,
  output logic                   OUT_SLAVE_MISO,
  output logic [PACK_LENGTH-1:0] OUT_SLAVE_RECEIVE_DATA,
  output logic                   OUT_SLAVE_DONE
);

  localparam int PL   = PACK_LENGTH;
  localparam int HALF = CLOCK_FREQUENCY / (2 * BIT_PER_SECOND);
  localparam int CW   = $clog2(HALF + 1);
  localparam int EW   = $clog2(2 * PL);
  localparam int BW   = $clog2(PL + 1);
  localparam int IW   = $clog2(PL);

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * PL - 1);
  localparam logic [BW-1:0] PL_CNT    = BW'(PL);
  localparam logic [BW-1:0] PL_LAST   = BW'(PL - 1);
  localparam logic          CPOL_B    = (CPOL != 0);
  localparam logic          CPHA_B    = (CPHA != 0);
  localparam logic          M_TX_MSB  = (MASTER_PACK_BIT_SEQUENCE_TRANSMIT != 0);
  localparam logic          M_RX_MSB  = (MASTER_PACK_BIT_SEQUENCE_RECEIVE != 0);
  localparam logic          S_TX_MSB  = (SLAVE_PACK_BIT_SEQUENCE_TRANSMIT != 0);
  localparam logic          S_RX_MSB  = (SLAVE_PACK_BIT_SEQUENCE_RECEIVE != 0);

  // Word position of the n-th bit on the wire for the chosen bit order.
  function automatic logic [IW-1:0] bit_idx(input logic [BW-1:0] n, input logic msb_first);
    logic [BW-1:0] k;
    k = msb_first ? (PL_LAST - n) : n;
    return k[IW-1:0];
  endfunction

  // ---------------------------------------------------------------- master
  typedef enum logic [2:0] {M_IDLE, M_SETUP, M_SHIFT, M_HOLD, M_DONE} m_state_t;

  m_state_t      m_state;
  logic          launch_q;
  logic [CW-1:0] m_cnt;
  logic [EW-1:0] m_edge;
  logic [PL-1:0] m_tx_word;
  logic [PL-1:0] m_rx_word;
  logic [BW-1:0] m_tx_cnt;
  logic [BW-1:0] m_rx_cnt;
  logic          launch_rise;
  logic          m_sample_edge;

  assign launch_rise   = IN_LAUNCH & ~launch_q;
  // The edge about to be produced is leading when SCLK currently sits at CPOL;
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  assign m_sample_edge = (OUT_SCLK == CPOL_B) ^ CPHA_B;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      m_state                 <= M_IDLE;
      launch_q                <= 1'b0;
      m_cnt                   <= '0;
      m_edge                  <= '0;
      m_tx_word               <= '0;
      m_rx_word               <= '0;
      m_tx_cnt                <= '0;
      m_rx_cnt                <= '0;
      OUT_CS                  <= 1'b1;
      OUT_SCLK                <= CPOL_B;
      OUT_MOSI                <= 1'b0;
      OUT_MASTER_RECEIVE_DATA <= '0;
      OUT_MASTER_ACTION_DONE  <= 1'b0;
    end else begin
      launch_q               <= IN_LAUNCH;
      OUT_MASTER_ACTION_DONE <= 1'b0;
      case (m_state)
        M_IDLE: begin
          if (launch_rise) begin
            m_tx_word <= IN_MASTER_DATA;
            m_rx_word <= '0;
            m_rx_cnt  <= '0;
            m_cnt     <= '0;
            m_edge    <= '0;
            OUT_CS    <= 1'b0;
            if (!CPHA_B) begin
              // First bit must be on the wire before the first (sampling) edge.
              OUT_MOSI <= IN_MASTER_DATA[bit_idx('0, M_TX_MSB)];
              m_tx_cnt <= BW'(1);
            end else begin
              m_tx_cnt <= '0;
            end
            m_state <= M_SETUP;
          end
        end
        M_SETUP: begin
          if (m_cnt == HALF_M1) begin
            m_cnt   <= '0;
            m_state <= M_SHIFT;
          end else begin
            m_cnt <= m_cnt + 1'b1;
          end
        end
        M_SHIFT: begin
          if (m_cnt == HALF_M1) begin
            m_cnt    <= '0;
            OUT_SCLK <= ~OUT_SCLK;
            m_edge   <= m_edge + 1'b1;
            if (m_sample_edge) begin
              if (m_rx_cnt != PL_CNT) begin
                m_rx_word[bit_idx(m_rx_cnt, M_RX_MSB)] <= IN_MISO;
                m_rx_cnt <= m_rx_cnt + 1'b1;
              end
            end else if (m_tx_cnt != PL_CNT) begin
              // With CPHA=0 the counter is already exhausted at the final trailing edge.
              OUT_MOSI <= m_tx_word[bit_idx(m_tx_cnt, M_TX_MSB)];
              m_tx_cnt <= m_tx_cnt + 1'b1;
            end
            if (m_edge == LAST_EDGE) begin
              m_state <= M_HOLD;
            end
          end else begin
            m_cnt <= m_cnt + 1'b1;
          end
        end
        M_HOLD: begin
          if (m_cnt == HALF_M1) begin
            m_cnt                   <= '0;
            OUT_CS                  <= 1'b1;
            OUT_SCLK                <= CPOL_B;
            OUT_MOSI                <= 1'b0;
            OUT_MASTER_RECEIVE_DATA <= m_rx_word;
            OUT_MASTER_ACTION_DONE  <= 1'b1;
            m_state                 <= M_DONE;
          end else begin
            m_cnt <= m_cnt + 1'b1;
          end
        end
        M_DONE: begin
          m_state <= M_IDLE;
        end
        default: begin
          m_state <= M_IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- slave
  logic          sclk_meta, sclk_sync, sclk_prev;
  logic          cs_meta, cs_sync, cs_prev;
  logic          mosi_meta, mosi_sync;
  logic [PL-1:0] s_tx_word;
  logic [PL-1:0] s_rx_word;
  logic [PL-1:0] s_rx_next;
  logic [BW-1:0] s_tx_cnt;
  logic [BW-1:0] s_rx_cnt;
  logic          s_sample_edge;

  // Synchronized SCLK has just moved: leading when it left CPOL.
  assign s_sample_edge = (sclk_sync != CPOL_B) ^ CPHA_B;

  // Receive word including the bit sampled this clock, so completion can publish it directly.
  always_comb begin
    s_rx_next = s_rx_word;
    s_rx_next[bit_idx(s_rx_cnt, S_RX_MSB)] = mosi_sync;
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      sclk_meta              <= CPOL_B;
      sclk_sync              <= CPOL_B;
      sclk_prev              <= CPOL_B;
      cs_meta                <= 1'b1;
      cs_sync                <= 1'b1;
      cs_prev                <= 1'b1;
      mosi_meta              <= 1'b0;
      mosi_sync              <= 1'b0;
      s_tx_word              <= '0;
      s_rx_word              <= '0;
      s_tx_cnt               <= '0;
      s_rx_cnt               <= '0;
      OUT_SLAVE_MISO         <= 1'b0;
      OUT_SLAVE_RECEIVE_DATA <= '0;
      OUT_SLAVE_DONE         <= 1'b0;
    end else begin
      sclk_meta      <= IN_SLAVE_SCLK;
      sclk_sync      <= sclk_meta;
      sclk_prev      <= sclk_sync;
      cs_meta        <= IN_SLAVE_CS;
      cs_sync        <= cs_meta;
      cs_prev        <= cs_sync;
      mosi_meta      <= IN_SLAVE_MOSI;
      mosi_sync      <= mosi_meta;
      OUT_SLAVE_DONE <= 1'b0;
      if (cs_sync) begin
        // Deselected (or aborted): partial word is simply never published.
        OUT_SLAVE_MISO <= 1'b0;
      end else if (cs_prev) begin
        s_tx_word <= IN_SLAVE_TRANSMIT_DATA;
        s_rx_word <= '0;
        s_rx_cnt  <= '0;
        if (!CPHA_B) begin
          OUT_SLAVE_MISO <= IN_SLAVE_TRANSMIT_DATA[bit_idx('0, S_TX_MSB)];
          s_tx_cnt       <= BW'(1);
        end else begin
          s_tx_cnt <= '0;
        end
      end else if (sclk_sync != sclk_prev) begin
        if (s_sample_edge) begin
          // Saturated counter swallows any surplus edges before CS rises.
          if (s_rx_cnt != PL_CNT) begin
            s_rx_word <= s_rx_next;
            s_rx_cnt  <= s_rx_cnt + 1'b1;
            if (s_rx_cnt == PL_LAST) begin
              OUT_SLAVE_RECEIVE_DATA <= s_rx_next;
              OUT_SLAVE_DONE         <= 1'b1;
            end
          end
        end else if (s_tx_cnt != PL_CNT) begin
          OUT_SLAVE_MISO <= s_tx_word[bit_idx(s_tx_cnt, S_TX_MSB)];
          s_tx_cnt       <= s_tx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_fpga_master_slave.sv
`timescale 1ns/1ps
// Bench: five instances, each with its master pins looped onto its own slave pins.
// inst0 CPOL0/CPHA1 (slave pins can be driven by the bench), inst1 00, inst2 10, inst3 11,
// inst4 CPOL0/CPHA0 with every bit-order parameter at 0.
module tb_spi_fpga_master_slave;

  localparam int N    = 5;
  localparam int PL   = 8;
  localparam int HALF = 4;
  localparam logic [N-1:0] CPOL_V  = 5'b01100;
  localparam logic [N-1:0] CPHA_V  = 5'b01001;
  localparam logic [N-1:0] ORDER_V = 5'b01111;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  launch;
  logic [PL-1:0] m_data [N];
  logic [PL-1:0] s_data [N];
  logic          cs_w [N];
  logic          sclk_w [N];
  logic          mosi_w [N];
  logic          smiso_w [N];
  logic          mdone_w [N];
  logic          sdone_w [N];
  logic [PL-1:0] mrx_w [N];
  logic [PL-1:0] srx_w [N];
  logic          s_cs_w [N];
  logic          s_sclk_w [N];
  logic          s_mosi_w [N];
  logic          direct, d_cs, d_sclk, d_mosi;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign s_cs_w[g]   = (g == 0 && direct) ? d_cs   : cs_w[g];
    assign s_sclk_w[g] = (g == 0 && direct) ? d_sclk : sclk_w[g];
    assign s_mosi_w[g] = (g == 0 && direct) ? d_mosi : mosi_w[g];

    spi_fpga_master_slave #(
      .BIT_PER_SECOND(6250000),
      .CLOCK_FREQUENCY(50000000),
      .PACK_LENGTH(PL),
      .CPOL(CPOL_V[g] ? 1 : 0),
      .CPHA(CPHA_V[g] ? 1 : 0),
      .MASTER_PACK_BIT_SEQUENCE_TRANSMIT(ORDER_V[g] ? 1 : 0),
      .MASTER_PACK_BIT_SEQUENCE_RECEIVE(ORDER_V[g] ? 1 : 0),
      .SLAVE_PACK_BIT_SEQUENCE_TRANSMIT(ORDER_V[g] ? 1 : 0),
      .SLAVE_PACK_BIT_SEQUENCE_RECEIVE(ORDER_V[g] ? 1 : 0)
    ) u_dut (
      .IN_CLOCK(clk),
      .IN_RESET_N(rst_n),
      .IN_LAUNCH(launch[g]),
      .IN_MASTER_DATA(m_data[g]),
      .IN_MISO(smiso_w[g]),
      .OUT_MOSI(mosi_w[g]),
      .OUT_CS(cs_w[g]),
      .OUT_SCLK(sclk_w[g]),
      .OUT_MASTER_RECEIVE_DATA(mrx_w[g]),
      .OUT_MASTER_ACTION_DONE(mdone_w[g]),
      .IN_SLAVE_TRANSMIT_DATA(s_data[g]),
      .IN_SLAVE_MOSI(s_mosi_w[g]),
      .IN_SLAVE_CS(s_cs_w[g]),
      .IN_SLAVE_SCLK(s_sclk_w[g]),
      .OUT_SLAVE_MISO(smiso_w[g]),
      .OUT_SLAVE_RECEIVE_DATA(srx_w[g]),
      .OUT_SLAVE_DONE(sdone_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event counters per instance, sampled on the falling edge.
  int   m_done_cnt [N];
  int   s_done_cnt [N];
  int   samp_cnt [N];
  int   cs_low_cnt [N];
  logic sclk_prev [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_done_cnt[i] <= 0;
        s_done_cnt[i] <= 0;
        samp_cnt[i]   <= 0;
        cs_low_cnt[i] <= 0;
      end else begin
        if (mdone_w[i]) m_done_cnt[i] <= m_done_cnt[i] + 1;
        if (sdone_w[i]) s_done_cnt[i] <= s_done_cnt[i] + 1;
        if (!cs_w[i]) cs_low_cnt[i] <= cs_low_cnt[i] + 1;
        if (!cs_w[i] && sclk_w[i] != sclk_prev[i] && ((sclk_w[i] != CPOL_V[i]) ^ CPHA_V[i]))
          samp_cnt[i] <= samp_cnt[i] + 1;
      end
      sclk_prev[i] <= sclk_w[i];
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            inst;
    logic [PL-1:0] m_rx;
    logic [PL-1:0] s_rx;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   base_m, base_s, base_samp, base_cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_mdone(input int g, input int target, input string tag);
    int n;
    n = 0;
    while (m_done_cnt[g] < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done within budget"}, 32'(m_done_cnt[g] >= target), 32'd1);
  endtask

  // Drive data, record the expected words, raise launch (optionally leaving it high).
  task automatic start_frame(input int g, input logic [PL-1:0] md, input logic [PL-1:0] sd,
                             input logic [PL-1:0] exp_m, input logic [PL-1:0] exp_s,
                             input string tag, input bit hold);
    exp_t e;
    @(negedge clk);
    m_data[g] = md;
    s_data[g] = sd;
    base_m    = m_done_cnt[g];
    base_s    = s_done_cnt[g];
    base_samp = samp_cnt[g];
    base_cs   = cs_low_cnt[g];
    e.inst = g;
    e.m_rx = exp_m;
    e.s_rx = exp_s;
    e.tag  = tag;
    sb.push_back(e);
    launch[g] = 1'b1;
    @(negedge clk);
    if (!hold) launch[g] = 1'b0;
  endtask

  task automatic finish_frame();
    exp_t e;
    int   g;
    g = sb[0].inst;
    wait_mdone(g, base_m + 1, sb[0].tag);
    repeat (10) @(negedge clk);
    e = sb.pop_front();
    check({e.tag, " master rx"}, 32'(mrx_w[g]), 32'(e.m_rx));
    check({e.tag, " slave rx"}, 32'(srx_w[g]), 32'(e.s_rx));
    check({e.tag, " master done pulses"}, 32'(m_done_cnt[g] - base_m), 32'd1);
    check({e.tag, " slave done pulses"}, 32'(s_done_cnt[g] - base_s), 32'd1);
    check({e.tag, " cs low clocks"}, 32'(cs_low_cnt[g] - base_cs), 32'((2 * PL + 2) * HALF));
    check({e.tag, " sample edges"}, 32'(samp_cnt[g] - base_samp), 32'(PL));
    check({e.tag, " sclk idle"}, 32'(sclk_w[g]), 32'(CPOL_V[g]));
    check({e.tag, " cs idle"}, 32'(cs_w[g]), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PL-1:0] pat;
    rst_n  = 1'b0;
    launch = '0;
    direct = 1'b0;
    d_cs   = 1'b1;
    d_sclk = 1'b0;
    d_mosi = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      s_data[i] = '0;
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    check("reset cs", 32'(cs_w[0]), 32'd1);
    check("reset sclk cpol0", 32'(sclk_w[0]), 32'd0);
    check("reset sclk cpol1", 32'(sclk_w[2]), 32'd1);
    check("reset mosi", 32'(mosi_w[0]), 32'd0);
    check("reset slave miso", 32'(smiso_w[0]), 32'd0);
    check("reset master rx", 32'(mrx_w[0]), 32'd0);
    check("reset slave rx", 32'(srx_w[0]), 32'd0);
    check("reset done pulses", 32'({mdone_w[0], sdone_w[0]}), 32'd0);

    // Loopback exchange in all four modes.
    start_frame(0, 8'hEA, 8'h53, 8'h53, 8'hEA, "mode01", 1'b0);
    finish_frame();
    start_frame(1, 8'hEA, 8'h53, 8'h53, 8'hEA, "mode00", 1'b0);
    finish_frame();
    start_frame(2, 8'hEA, 8'h53, 8'h53, 8'hEA, "mode10", 1'b0);
    finish_frame();
    start_frame(3, 8'hEA, 8'h53, 8'h53, 8'hEA, "mode11", 1'b0);
    finish_frame();

    // LSB-first both ways: 0x01 goes out 1,0,..,0 and lands in the LSB -> slave gets 0x01;
    // 0x80 goes out 0,..,0,1 and lands in the LSB-first word -> master gets 0x80.
    start_frame(4, 8'h01, 8'h80, 8'h80, 8'h01, "lsb first", 1'b0);
    check("lsb first first mosi bit", 32'(mosi_w[4]), 32'd1);
    repeat (6) @(negedge clk);
    check("lsb first first miso bit", 32'(smiso_w[4]), 32'd0);
    repeat (63) @(negedge clk);
    check("lsb first last miso bit", 32'(smiso_w[4]), 32'd1);
    finish_frame();

    // Launch held high, with a second rising edge mid-frame: one frame only.
    start_frame(1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, "launch held", 1'b1);
    repeat (20) @(negedge clk);
    launch[1] = 1'b0;
    repeat (2) @(negedge clk);
    launch[1] = 1'b1;
    finish_frame();
    repeat (100) @(negedge clk);
    check("launch held total frames", 32'(m_done_cnt[1] - base_m), 32'd1);
    check("launch held cs idle", 32'(cs_w[1]), 32'd1);
    launch[1] = 1'b0;

    // Slave abort after 4 bits, bench driving the slave pins (CPOL0/CPHA1).
    @(negedge clk);
    direct    = 1'b1;
    s_data[0] = 8'h53;
    base_s    = s_done_cnt[0];
    pat       = 8'h53;
    d_cs      = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      d_sclk = 1'b1;
      d_mosi = 1'b1;
      repeat (8) @(negedge clk);
      check($sformatf("abort miso bit %0d", b), 32'(smiso_w[0]), 32'(pat[PL-1-b]));
      d_sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    d_cs = 1'b1;
    repeat (8) @(negedge clk);
    check("abort slave rx unchanged", 32'(srx_w[0]), 32'h0EA);
    check("abort no slave done", 32'(s_done_cnt[0] - base_s), 32'd0);
    check("abort miso low", 32'(smiso_w[0]), 32'd0);
    direct = 1'b0;
    d_mosi = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a master frame, then a clean frame.
    m_data[0] = 8'h96;
    s_data[0] = 8'h69;
    launch[0] = 1'b1;
    @(negedge clk);
    launch[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("pre-reset cs low", 32'(cs_w[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid-frame reset cs", 32'(cs_w[0]), 32'd1);
    check("mid-frame reset sclk", 32'(sclk_w[0]), 32'd0);
    check("mid-frame reset master rx", 32'(mrx_w[0]), 32'd0);
    check("mid-frame reset slave rx", 32'(srx_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_frame(0, 8'h96, 8'h69, 8'h69, 8'h96, "after reset", 1'b0);
    finish_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
